// File: rtl/burst_bus_fifo_pkg.sv
// ============================================================================
// burst_bus_fifo_pkg : shared widths, wrap arithmetic and error-pulse type
// Revision: 1.0
// ============================================================================
`default_nettype none

package burst_bus_fifo_pkg;

    typedef struct packed {
        logic ovf;
        logic udf;
    } err_pulse_t;

    localparam err_pulse_t c_ERR_NONE = '{ovf: 1'b0, udf: 1'b0};

    // Bits needed to hold the values 0..max_val inclusive
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Operands are always below size, so one conditional subtract is enough
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned size);
        return (a + b >= size) ? (a + b - size) : (a + b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/burst_bus_fifo_if.sv
// ============================================================================
// burst_bus_fifo_if : push/pop/status bundle of the burst bus FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

interface burst_bus_fifo_if
    import burst_bus_fifo_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int WIDTH     = 32,
    parameter int IN_WORDS  = 6,
    parameter int OUT_WORDS = 6
);
    localparam int c_CW  = cnt_width(SIZE);
    localparam int c_WCW = cnt_width(IN_WORDS);
    localparam int c_RCW = cnt_width(OUT_WORDS);

    logic                          clr;
    logic                          wr_en;
    logic [c_WCW-1:0]              wr_cnt;
    logic [IN_WORDS*WIDTH-1:0]     wr_data;
    logic                          wr_ready;
    logic                          rd_en;
    logic [c_RCW-1:0]              rd_cnt;
    logic                          rd_ready;
    logic [OUT_WORDS*WIDTH-1:0]    rd_data;
    logic [c_CW-1:0]               count;
    logic                          full;
    logic                          empty;
    logic                          almost_full;
    logic                          almost_empty;
    logic                          ovf_err;
    logic                          udf_err;

    modport slave (
        input  clr, wr_en, wr_cnt, wr_data, rd_en, rd_cnt,
        output wr_ready, rd_ready, rd_data, count, full, empty,
               almost_full, almost_empty, ovf_err, udf_err
    );

    modport master (
        output clr, wr_en, wr_cnt, wr_data, rd_en, rd_cnt,
        input  wr_ready, rd_ready, rd_data, count, full, empty,
               almost_full, almost_empty, ovf_err, udf_err
    );

endinterface

`default_nettype wire

// File: rtl/burst_bus_fifo_mem.sv
// ============================================================================
// burst_fifo_mem : SIZE x WIDTH storage, multi-lane wrapped write and
//                  count-masked show-ahead read window
// Revision: 1.0
// ============================================================================
`default_nettype none

module burst_fifo_mem
    import burst_bus_fifo_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int WIDTH     = 32,
    parameter int IN_WORDS  = 6,
    parameter int OUT_WORDS = 6,
    localparam int PW       = $clog2(SIZE),
    localparam int CW       = cnt_width(SIZE),
    localparam int WCW      = cnt_width(IN_WORDS)
) (
    input  wire logic                       clk,
    input  wire logic                       i_we,
    input  wire logic [PW-1:0]              i_wr_ptr,
    input  wire logic [WCW-1:0]             i_wr_cnt,
    input  wire logic [IN_WORDS*WIDTH-1:0]  i_wr_data,
    input  wire logic [PW-1:0]              i_rd_ptr,
    input  wire logic [CW-1:0]              i_count,
    output logic      [OUT_WORDS*WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [SIZE];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < IN_WORDS; i++) begin
                if (32'(i) < 32'(i_wr_cnt)) begin
                    r_mem[PW'(wrap_add(32'(i_wr_ptr), 32'(i), SIZE))] <= i_wr_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Lanes beyond the occupancy read as zero so stale or never-written words stay hidden
    generate
        for (genvar j = 0; j < OUT_WORDS; j++) begin : g_rd_lane
            logic [PW-1:0] w_addr;
            assign w_addr = PW'(wrap_add(32'(i_rd_ptr), 32'(j), SIZE));
            assign o_rd_data[j*WIDTH +: WIDTH] = (32'(j) < 32'(i_count)) ? r_mem[w_addr] : '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/burst_bus_fifo.sv
// ============================================================================
// burst_bus_fifo : multi-word push/pop FIFO with exact occupancy, watermarks
//                  and registered overflow/underflow pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module burst_bus_fifo
    import burst_bus_fifo_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int WIDTH     = 32,
    parameter int IN_WORDS  = 6,
    parameter int OUT_WORDS = 6,
    parameter int AF_FREE   = 3,
    parameter int AE_LEVEL  = 2
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    burst_bus_fifo_if.slave  s_bus
);

    localparam int c_PW = $clog2(SIZE);
    localparam int c_CW = cnt_width(SIZE);

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    err_pulse_t      r_err;

    logic [31:0]     w_free;
    logic            w_wr_ok;
    logic            w_rd_ok;
    logic [31:0]     w_wr_n;
    logic [31:0]     w_rd_n;

    // Both directions judge against the pre-cycle occupancy; no pop-to-push bypass
    assign w_free  = SIZE - 32'(r_count);
    assign w_wr_ok = s_bus.wr_en && !s_bus.clr
                     && (32'(s_bus.wr_cnt) <= IN_WORDS) && (32'(s_bus.wr_cnt) <= w_free);
    assign w_rd_ok = s_bus.rd_en && !s_bus.clr
                     && (32'(s_bus.rd_cnt) <= OUT_WORDS) && (32'(s_bus.rd_cnt) <= 32'(r_count));
    assign w_wr_n  = w_wr_ok ? 32'(s_bus.wr_cnt) : 32'd0;
    assign w_rd_n  = w_rd_ok ? 32'(s_bus.rd_cnt) : 32'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= c_ERR_NONE;
        end else if (s_bus.clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= c_ERR_NONE;
        end else begin
            r_wr_ptr  <= c_PW'(wrap_add(32'(r_wr_ptr), w_wr_n, SIZE));
            r_rd_ptr  <= c_PW'(wrap_add(32'(r_rd_ptr), w_rd_n, SIZE));
            r_count   <= c_CW'(32'(r_count) + w_wr_n - w_rd_n);
            r_err.ovf <= s_bus.wr_en && !w_wr_ok;
            r_err.udf <= s_bus.rd_en && !w_rd_ok;
        end
    end

    burst_fifo_mem #(
        .SIZE      (SIZE),
        .WIDTH     (WIDTH),
        .IN_WORDS  (IN_WORDS),
        .OUT_WORDS (OUT_WORDS)
    ) u_mem (
        .clk       (clk),
        .i_we      (w_wr_ok),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_cnt  (s_bus.wr_cnt),
        .i_wr_data (s_bus.wr_data),
        .i_rd_ptr  (r_rd_ptr),
        .i_count   (r_count),
        .o_rd_data (s_bus.rd_data)
    );

    assign s_bus.wr_ready     = w_wr_ok;
    assign s_bus.rd_ready     = w_rd_ok;
    assign s_bus.count        = r_count;
    assign s_bus.full         = (r_count == c_CW'(SIZE));
    assign s_bus.empty        = (r_count == '0);
    assign s_bus.almost_full  = (w_free <= AF_FREE);
    assign s_bus.almost_empty = (32'(r_count) <= AE_LEVEL);
    assign s_bus.ovf_err      = r_err.ovf;
    assign s_bus.udf_err      = r_err.udf;

endmodule

`default_nettype wire
